// File: rtl/program_loader.sv
// program_loader: takes 16-bit instruction words from a host over a valid/ready
// stream and writes them one after another into instruction memory, starting at
// BASE_ADDR. The fetch stage and the core are held in reset for the whole load
// and are released a fixed number of cycles after the last write.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset; resets asserted, waiting for start
// CLEAR | one cycle; count, overflow and address pointer already cleared
// LOAD  | accepting host words, one memory write per accepted word
// HOLD  | last write completing, resets held for RELEASE_CYCLES cycles
// RUN   | core released; word_count/overflow kept for host readback
module program_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int          MEM_DEPTH      = 1024,
  parameter int          RELEASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        write_enable_fm,
  output logic [15:0] write_data_fm,
  output logic [31:0] write_addr_fm,
  output logic        rst_fm,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [16:0] word_count
);

  localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);
  localparam int          TW    = $clog2(RELEASE_CYCLES + 1);
  // Timer counts down to zero, so HOLD lasts exactly RELEASE_CYCLES cycles.
  localparam logic [TW-1:0] TIMER_LOAD = TW'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_timer;
  logic [31:0]     r_ptr;
  logic [16:0]     r_count;
  logic            r_overflow;
  logic            r_we;
  logic [15:0]     r_wdata;
  logic [31:0]     r_waddr;
  logic            w_in_ready;
  logic            w_hs;
  logic            w_start_ok;
  logic            w_hold_entry;
  logic [16:0]     w_count_inc;
  logic            w_depth_hit;
  logic            w_in_reset;

  assign w_count_inc = r_count + 17'd1;
  assign w_depth_hit = (w_count_inc == DEPTH);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next       = r_state;
    w_in_ready   = 1'b0;
    w_start_ok   = 1'b0;
    w_hold_entry = 1'b0;
    w_in_reset   = 1'b1;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_ok = 1'b1;
          w_next     = CLEAR;
        end
      end
      CLEAR: begin
        busy   = 1'b1;
        w_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        w_in_ready = (r_count < DEPTH);
        if (in_valid && w_in_ready && (in_last || w_depth_hit)) begin
          w_hold_entry = 1'b1;
          w_next       = HOLD;
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (r_timer == '0) begin
          w_next = RUN;
        end
      end
      RUN: begin
        done       = 1'b1;
        w_in_reset = 1'b0;
        if (start) begin
          w_start_ok = 1'b1;
          w_next     = CLEAR;
        end
      end
      default: w_next = IDLE;
    endcase
    w_hs = in_valid & w_in_ready;
  end

  // Write port, address pointer, word counter, overflow flag and release timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we       <= 1'b0;
      r_wdata    <= 16'd0;
      r_waddr    <= BASE_ADDR;
      r_ptr      <= BASE_ADDR;
      r_count    <= 17'd0;
      r_overflow <= 1'b0;
      r_timer    <= '0;
    end else begin
      r_we <= w_hs;
      if (w_hs) begin
        r_wdata <= in_data;
        r_waddr <= r_ptr;
        r_ptr   <= r_ptr + 32'd1;
        r_count <= w_count_inc;
        if (!in_last && w_depth_hit) begin
          r_overflow <= 1'b1;
        end
      end
      // Clearing on the start edge means CLEAR already shows a zero count.
      if (w_start_ok) begin
        r_count    <= 17'd0;
        r_overflow <= 1'b0;
        r_ptr      <= BASE_ADDR;
      end
      if (w_hold_entry) begin
        r_timer <= TIMER_LOAD;
      end else if (r_state == HOLD && r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  assign in_ready        = w_in_ready;
  assign write_enable_fm = r_we;
  assign write_data_fm   = r_wdata;
  assign write_addr_fm   = r_waddr;
  assign rst_fm          = w_in_reset;
  assign core_reset      = w_in_reset;
  assign overflow        = r_overflow;
  assign word_count      = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: main instance with default depth, second instance
// with MEM_DEPTH=4 for the overflow path. Expected memory writes are queued as
// words are offered and checked by a monitor whenever a write strobe appears.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        in_ready, write_enable_fm, rst_fm, core_reset, busy, done, overflow;
  logic [15:0] write_data_fm;
  logic [31:0] write_addr_fm;
  logic [16:0] word_count;

  logic        start4 = 1'b0, valid4 = 1'b0, last4 = 1'b0;
  logic [15:0] data4 = 16'd0;
  logic        ready4, we4, rst_fm4, core_reset4, busy4, done4, overflow4;
  logic [15:0] wdata4;
  logic [31:0] waddr4;
  logic [16:0] count4;

  int total = 0;
  int bad   = 0;
  logic [47:0] q[$];
  logic [47:0] q4[$];

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .write_enable_fm(write_enable_fm),
    .write_data_fm(write_data_fm), .write_addr_fm(write_addr_fm), .rst_fm(rst_fm),
    .core_reset(core_reset), .busy(busy), .done(done), .overflow(overflow),
    .word_count(word_count)
  );

  program_loader #(.MEM_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .in_valid(valid4), .in_data(data4),
    .in_last(last4), .in_ready(ready4), .write_enable_fm(we4),
    .write_data_fm(wdata4), .write_addr_fm(waddr4), .rst_fm(rst_fm4),
    .core_reset(core_reset4), .busy(busy4), .done(done4), .overflow(overflow4),
    .word_count(count4)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe must match the oldest expected write.
  always @(posedge clk) begin
    logic [47:0] exp_w;
    #1;
    if (write_enable_fm === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected got addr=%0h data=%0h, none expected", write_addr_fm, write_data_fm);
      end else begin
        exp_w = q.pop_front();
        if ({write_addr_fm, write_data_fm} !== exp_w) begin
          bad++;
          $display("FAIL wr_main got addr=%0h data=%0h exp addr=%0h data=%0h",
                   write_addr_fm, write_data_fm, exp_w[47:16], exp_w[15:0]);
        end
      end
    end
    if (we4 === 1'b1) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL wr4_unexpected got addr=%0h data=%0h, none expected", waddr4, wdata4);
      end else begin
        exp_w = q4.pop_front();
        if ({waddr4, wdata4} !== exp_w) begin
          bad++;
          $display("FAIL wr_d4 got addr=%0h data=%0h exp addr=%0h data=%0h",
                   waddr4, wdata4, exp_w[47:16], exp_w[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start and advance through CLEAR into LOAD.
  task automatic begin_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || rst_fm !== 1'b1 || core_reset !== 1'b1 || word_count !== 17'd0 ||
        overflow !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL clear_state got busy=%b rst_fm=%b core_reset=%b count=%0d ovf=%b done=%b exp 1 1 1 0 0 0",
               busy, rst_fm, core_reset, word_count, overflow, done);
    end
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    q.push_back({addr, d});
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++;
    if (write_enable_fm !== 1'b1 || write_addr_fm !== addr || write_data_fm !== d) begin
      bad++;
      $display("FAIL strobe_next_cycle got we=%b addr=%0h data=%0h exp 1 %0h %0h",
               write_enable_fm, write_addr_fm, write_data_fm, addr, d);
    end
  endtask

  task automatic check_run(input logic [16:0] exp_count, input logic exp_ovf);
    total++;
    if (done !== 1'b1 || rst_fm !== 1'b0 || core_reset !== 1'b0 || busy !== 1'b0 ||
        word_count !== exp_count || overflow !== exp_ovf) begin
      bad++;
      $display("FAIL run_state got done=%b rst_fm=%b core_reset=%b busy=%b count=%0d ovf=%b exp 1 0 0 0 %0d %b",
               done, rst_fm, core_reset, busy, word_count, overflow, exp_count, exp_ovf);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (write_enable_fm !== 1'b0 || write_data_fm !== 16'd0 || write_addr_fm !== 32'd0 ||
        rst_fm !== 1'b1 || core_reset !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || overflow !== 1'b0 || word_count !== 17'd0) begin
      bad++;
      $display("FAIL reset_values got we=%b data=%0h addr=%0h rst=%b core=%b rdy=%b busy=%b done=%b ovf=%b cnt=%0d",
               write_enable_fm, write_data_fm, write_addr_fm, rst_fm, core_reset, in_ready, busy,
               done, overflow, word_count);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_load();
    begin_load();
    send_word(32'd0, 16'hA001, 1'b0);
    send_word(32'd1, 16'hA002, 1'b0);
    send_word(32'd2, 16'hA003, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (write_enable_fm !== 1'b0 || rst_fm !== 1'b1 || core_reset !== 1'b1 || busy !== 1'b0 ||
        in_ready !== 1'b0 || word_count !== 17'd0) begin
      bad++;
      $display("FAIL reset_mid_load got we=%b rst_fm=%b core=%b busy=%b rdy=%b cnt=%0d exp 0 1 1 0 0 0",
               write_enable_fm, rst_fm, core_reset, busy, in_ready, word_count);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    begin_load();
    send_word(32'd0, 16'h1111, 1'b0);
    send_word(32'd1, 16'h2222, 1'b0);
    send_word(32'd2, 16'h3333, 1'b1);
    total++;
    if (busy !== 1'b1 || rst_fm !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL hold_first got busy=%b rst_fm=%b rdy=%b done=%b exp 1 1 0 0", busy, rst_fm, in_ready, done);
    end
    tick();
    total++;
    if (rst_fm !== 1'b1 || core_reset !== 1'b1 || write_enable_fm !== 1'b0) begin
      bad++;
      $display("FAIL hold_second got rst_fm=%b core=%b we=%b exp 1 1 0", rst_fm, core_reset, write_enable_fm);
    end
    tick();
    check_run(17'd3, 1'b0);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL b2b_pending got %0d writes outstanding exp 0", q.size());
    end
  endtask

  task automatic test_valid_gap();
    begin_load();
    send_word(32'd0, 16'hBEEF, 1'b0);
    tick();
    total++;
    if (write_enable_fm !== 1'b0 || word_count !== 17'd1) begin
      bad++;
      $display("FAIL gap_no_write got we=%b cnt=%0d exp 0 1", write_enable_fm, word_count);
    end
    send_word(32'd1, 16'hCAFE, 1'b1);
    tick();
    tick();
    check_run(17'd2, 1'b0);
  endtask

  task automatic test_overflow();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (ready4 !== (i < 4)) begin
        bad++;
        $display("FAIL ovf_ready word=%0d got %b exp %b", i, ready4, (i < 4));
      end
      valid4 = 1'b1;
      data4  = 16'h4000 + 16'(i);
      if (i < 4) q4.push_back({32'(i), data4});
      tick();
    end
    valid4 = 1'b0;
    total++;
    if (done4 !== 1'b1 || overflow4 !== 1'b1 || count4 !== 17'd4 || rst_fm4 !== 1'b0 ||
        core_reset4 !== 1'b0 || q4.size() != 0) begin
      bad++;
      $display("FAIL overflow_end got done=%b ovf=%b cnt=%0d rst=%b core=%b pending=%0d exp 1 1 4 0 0 0",
               done4, overflow4, count4, rst_fm4, core_reset4, q4.size());
    end
  endtask

  task automatic test_start_handling();
    begin_load();
    start = 1'b1;
    send_word(32'd0, 16'h7001, 1'b0);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || word_count !== 17'd1) begin
      bad++;
      $display("FAIL start_in_load got busy=%b rdy=%b cnt=%0d exp 1 1 1", busy, in_ready, word_count);
    end
    send_word(32'd1, 16'h7002, 1'b1);
    tick();
    tick();
    check_run(17'd2, 1'b0);
    begin_load();
    send_word(32'd0, 16'h5A5A, 1'b1);
    tick();
    tick();
    check_run(17'd1, 1'b0);
  endtask

  task automatic test_idle_valid();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (in_ready !== 1'b0 || write_enable_fm !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_valid cycle=%0d got rdy=%b we=%b done=%b busy=%b exp 0 0 0 0",
                 i, in_ready, write_enable_fm, done, busy);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_back_to_back();
    test_valid_gap();
    test_overflow();
    test_start_handling();
    test_idle_valid();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
